// File: rtl/topic_sampler.sv
// topic_sampler: collects per-topic LDA counts, builds saturating cumulative weights with a
// serial restoring divider, then draws a topic index from an internal Galois LFSR.
module topic_sampler #(
    parameter int unsigned NUM_TOPICS = 4,
    parameter int unsigned ALPHA      = 1,
    parameter int unsigned BETA       = 1,
    parameter int unsigned VBETA      = 16384,
    parameter int unsigned FRAC_BITS  = 16,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2345
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [32*NUM_TOPICS-1:0]   i_nw,
    input  logic [32*NUM_TOPICS-1:0]   i_nw_sum,
    input  logic [32*NUM_TOPICS-1:0]   i_nd,
    input  logic [NUM_TOPICS-1:0]      i_valid,
    output logic [31:0]                o_new_topic,
    output logic                       o_topic_valid,
    output logic                       o_busy,
    output logic                       o_err
);
    localparam int unsigned KW   = $clog2(NUM_TOPICS);
    localparam int unsigned DvdW = 34 + FRAC_BITS;
    localparam logic [31:0] Taps = 32'h8020_0003;
    localparam logic [KW-1:0] LastK = KW'(NUM_TOPICS - 1);

    typedef enum logic [2:0] {StCollect, StCalc, StDraw, StScan, StEmit} state_e;

    state_e                state_q, state_d;
    logic [NUM_TOPICS-1:0] got_q, got_d;
    logic [15:0]           nw_q [NUM_TOPICS];
    logic [15:0]           nw_d [NUM_TOPICS];
    logic [15:0]           nd_q [NUM_TOPICS];
    logic [15:0]           nd_d [NUM_TOPICS];
    logic [31:0]           nws_q [NUM_TOPICS];
    logic [31:0]           nws_d [NUM_TOPICS];
    logic [31:0]           cum_q [NUM_TOPICS];
    logic [31:0]           cum_d [NUM_TOPICS];
    logic [KW-1:0]         k_q, k_d, j_q, j_d;
    logic [5:0]            cyc_q, cyc_d;
    logic [47:0]           dvd_q, dvd_d, quo_q, quo_d;
    logic [31:0]           rem_q, rem_d, dsr_q, dsr_d;
    logic                  ovf_q, ovf_d;
    logic [31:0]           thr_q, thr_d, lfsr_q, lfsr_d, topic_q, topic_d;
    logic                  valid_q, valid_d, busy_q, busy_d, err_q, err_d;

    logic [16:0]           op_a, op_b;
    logic [33:0]           prod;
    logic [DvdW-1:0]       dvd_full;
    logic                  dvd_hi;
    logic [31:0]           dsr_new;
    logic [32:0]           rem_sh;
    logic [31:0]           w, cum_prev;
    logic [32:0]           cum_sum;
    logic [47:0]           thr_prod;

    always_comb begin
        state_d = state_q;
        got_d   = got_q;
        nw_d    = nw_q;
        nd_d    = nd_q;
        nws_d   = nws_q;
        cum_d   = cum_q;
        k_d     = k_q;
        j_d     = j_q;
        cyc_d   = cyc_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        ovf_d   = ovf_q;
        thr_d   = thr_q;
        lfsr_d  = lfsr_q;
        topic_d = topic_q;
        err_d   = err_q | ((state_q != StCollect) & (|i_valid));

        op_a     = 17'(nw_q[k_q]) + 17'(BETA);
        op_b     = 17'(nd_q[k_q]) + 17'(ALPHA);
        prod     = 34'(op_a) * 34'(op_b);
        dvd_full = DvdW'(prod) << FRAC_BITS;
        // Operands are clamped, so anything above bit 47 can only be the single bit 2^48.
        dvd_hi   = |dvd_full[DvdW-1:48];
        dsr_new  = nws_q[k_q] + 32'(VBETA);
        if (dsr_new == 32'd0) begin
            dsr_new = 32'd1;
        end
        rem_sh   = {rem_q, dvd_q[47]};
        w        = (ovf_q || (|quo_q[47:32])) ? 32'hFFFF_FFFF : quo_q[31:0];
        cum_prev = (k_q == '0) ? 32'd0 : cum_q[k_q - KW'(1)];
        cum_sum  = {1'b0, cum_prev} + {1'b0, w};
        thr_prod = 48'(lfsr_q[15:0]) * 48'(cum_q[NUM_TOPICS-1]);

        unique case (state_q)
            StCollect: begin
                for (int unsigned t = 0; t < NUM_TOPICS; t++) begin
                    if (i_valid[t]) begin
                        nw_d[t]  = (|i_nw[32*t+16 +: 16]) ? 16'hFFFF : i_nw[32*t +: 16];
                        nd_d[t]  = (|i_nd[32*t+16 +: 16]) ? 16'hFFFF : i_nd[32*t +: 16];
                        nws_d[t] = i_nw_sum[32*t +: 32];
                        got_d[t] = 1'b1;
                    end
                end
                if (&got_d) begin
                    state_d = StCalc;
                    k_d     = '0;
                    cyc_d   = '0;
                end
            end
            StCalc: begin
                if (cyc_q == 6'd0) begin
                    // Bit 48 is pre-divided here so the remaining 48 bits fit 48 cycles.
                    dvd_d = dvd_full[47:0];
                    dsr_d = dsr_new;
                    ovf_d = dvd_hi && (dsr_new == 32'd1);
                    rem_d = (dvd_hi && (dsr_new != 32'd1)) ? 32'd1 : 32'd0;
                    quo_d = '0;
                    cyc_d = 6'd1;
                end else if (cyc_q <= 6'd48) begin
                    if (rem_sh >= {1'b0, dsr_q}) begin
                        rem_d = 32'(rem_sh - {1'b0, dsr_q});
                        quo_d = {quo_q[46:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[31:0];
                        quo_d = {quo_q[46:0], 1'b0};
                    end
                    dvd_d = dvd_q << 1;
                    cyc_d = cyc_q + 6'd1;
                end else begin
                    cum_d[k_q] = cum_sum[32] ? 32'hFFFF_FFFF : cum_sum[31:0];
                    cyc_d      = '0;
                    if (k_q == LastK) begin
                        state_d = StDraw;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            StDraw: begin
                thr_d   = 32'(thr_prod >> 16);
                lfsr_d  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? Taps : 32'd0);
                j_d     = '0;
                state_d = StScan;
            end
            StScan: begin
                if ((cum_q[j_q] > thr_q) || (j_q == LastK)) begin
                    topic_d = 32'(j_q);
                    state_d = StEmit;
                end else begin
                    j_d = j_q + KW'(1);
                end
            end
            StEmit: begin
                got_d   = '0;
                state_d = StCollect;
            end
            default: state_d = StCollect;
        endcase

        valid_d = (state_d == StEmit);
        busy_d  = (state_d != StCollect);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StCollect;
            got_q   <= '0;
            nw_q    <= '{default: '0};
            nd_q    <= '{default: '0};
            nws_q   <= '{default: '0};
            cum_q   <= '{default: '0};
            k_q     <= '0;
            j_q     <= '0;
            cyc_q   <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= 32'd1;
            ovf_q   <= 1'b0;
            thr_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            topic_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            got_q   <= got_d;
            nw_q    <= nw_d;
            nd_q    <= nd_d;
            nws_q   <= nws_d;
            cum_q   <= cum_d;
            k_q     <= k_d;
            j_q     <= j_d;
            cyc_q   <= cyc_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            ovf_q   <= ovf_d;
            thr_q   <= thr_d;
            lfsr_q  <= lfsr_d;
            topic_q <= topic_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign o_new_topic   = topic_q;
    assign o_topic_valid = valid_q;
    assign o_busy        = busy_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_topic_sampler.sv
// Bench for topic_sampler: two instances with different LFSR seeds share one stimulus stream
// and are checked every cycle against an arithmetic model of weights, threshold and timing.
module tb_topic_sampler;
    localparam int N = 4;
    localparam logic [31:0] SeedA = 32'h0000_8000;
    localparam logic [31:0] SeedB = 32'h0000_0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [32*N-1:0] nw_bus = '0, nws_bus = '0, nd_bus = '0;
    logic [N-1:0] vld = '0;
    logic [31:0] nt [2];
    logic tv [2], bsy [2], er [2];

    topic_sampler #(.NUM_TOPICS(N), .ALPHA(1), .BETA(1), .VBETA(16), .FRAC_BITS(16),
                    .LFSR_SEED(SeedA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_nw(nw_bus), .i_nw_sum(nws_bus), .i_nd(nd_bus),
        .i_valid(vld), .o_new_topic(nt[0]), .o_topic_valid(tv[0]), .o_busy(bsy[0]),
        .o_err(er[0]));

    topic_sampler #(.NUM_TOPICS(N), .ALPHA(1), .BETA(1), .VBETA(16), .FRAC_BITS(16),
                    .LFSR_SEED(SeedB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_nw(nw_bus), .i_nw_sum(nws_bus), .i_nd(nd_bus),
        .i_valid(vld), .o_new_topic(nt[1]), .o_topic_valid(tv[1]), .o_busy(bsy[1]),
        .o_err(er[1]));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    bit chk_en = 1'b0;

    // Model state: target counts, per-instance LFSR and expected draw timing.
    logic [31:0] t_nw [N], t_nd [N], t_nws [N];
    logic [31:0] m_nw [N], m_nd [N], m_nws [N];
    logic [31:0] m_lfsr [2] = '{SeedA, SeedB};
    logic [31:0] m_topic [2] = '{32'd0, 32'd0};
    logic [31:0] m_prev [2] = '{32'd0, 32'd0};
    logic [31:0] m_thr [2];
    logic [31:0] m_total;
    int m_off [2] = '{0, 0};
    int m_cap = -1;
    int m_err_at = -1;
    int obs_valid [2] = '{-1, -1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_draw(input logic [31:0] lfsr, output int j,
                                       output logic [31:0] thr, output logic [31:0] total);
        longint unsigned cum [N];
        longint unsigned a, b, d, q, acc;
        logic [31:0] d32;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            a   = ((m_nw[k] > 32'd65535) ? 64'd65535 : 64'(m_nw[k])) + 64'd1;
            b   = ((m_nd[k] > 32'd65535) ? 64'd65535 : 64'(m_nd[k])) + 64'd1;
            d32 = m_nws[k] + 32'd16;
            d   = (d32 == 32'd0) ? 64'd1 : 64'(d32);
            q   = ((a * b) << 16) / d;
            if (q > 64'hFFFF_FFFF) q = 64'hFFFF_FFFF;
            acc = acc + q;
            if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
            cum[k] = acc;
        end
        thr = 32'(((64'(lfsr) & 64'hFFFF) * cum[N-1]) >> 16);
        j = N - 1;
        for (int k = N - 1; k >= 0; k--) if (cum[k] > 64'(thr)) j = k;
        total = 32'(cum[N-1]);
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic bit exp_tv(input int i);
        return (m_cap >= 0) && (cyc == m_cap + m_off[i]);
    endfunction
    function automatic bit exp_busy(input int i);
        return (m_cap >= 0) && (cyc > m_cap) && (cyc <= m_cap + m_off[i]);
    endfunction
    function automatic logic [31:0] exp_topic(input int i);
        return ((m_cap >= 0) && (cyc >= m_cap + m_off[i])) ? m_topic[i] : m_prev[i];
    endfunction
    function automatic int end_cycle();
        return m_cap + ((m_off[0] > m_off[1]) ? m_off[0] : m_off[1]);
    endfunction

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 2; i++) begin
                    if (tv[i] === 1'b1) obs_valid[i] = cyc;
                    check($sformatf("topic_valid[%0d]", i), 32'(tv[i]), 32'(exp_tv(i)));
                    check($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(exp_busy(i)));
                    check($sformatf("new_topic[%0d]", i), nt[i], exp_topic(i));
                    check($sformatf("err[%0d]", i), 32'(er[i]),
                          32'((m_err_at >= 0) && (cyc >= m_err_at)));
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage();
        for (int k = 0; k < N; k++) begin
            nw_bus[32*k +: 32]  = $urandom;
            nd_bus[32*k +: 32]  = $urandom;
            nws_bus[32*k +: 32] = $urandom;
        end
        vld = '0;
    endtask

    task automatic drive(input int k, input bit fin);
        nw_bus[32*k +: 32]  = fin ? t_nw[k] : $urandom;
        nd_bus[32*k +: 32]  = fin ? t_nd[k] : $urandom;
        nws_bus[32*k +: 32] = fin ? t_nws[k] : $urandom;
        vld[k] = 1'b1;
    endtask

    task automatic wait_idle();
        while ((m_cap >= 0) && (cyc <= end_cycle())) step();
    endtask

    task automatic set_all(input logic [31:0] a, input logic [31:0] d, input logic [31:0] s);
        for (int k = 0; k < N; k++) begin
            t_nw[k] = a; t_nd[k] = d; t_nws[k] = s;
        end
    endtask

    function automatic logic [31:0] rand_count();
        logic [31:0] v;
        case ($urandom_range(3, 0))
            0: v = 32'd0;
            1: v = $urandom_range(200, 0);
            2: v = $urandom;
            default: v = 32'hFFFF_FFFF;
        endcase
        return v;
    endfunction

    task automatic txn(input bit simul, input logic [N-1:0] force_rep, input bit inj_err,
                       input bit inj_rst);
        int lastk, j;
        logic [N-1:0] rep, done, jdone, lmask;
        wait_idle();
        m_prev[0] = m_topic[0];
        m_prev[1] = m_topic[1];
        m_cap = -1;
        garbage();
        if (simul) begin
            for (int k = 0; k < N; k++) drive(k, 1'b1);
        end else begin
            lastk = $urandom_range(N - 1, 0);
            if (force_rep[lastk]) lastk = (lastk + 1) % N;
            lmask = N'(1) << lastk;
            rep = (N'($urandom) | force_rep) & ~lmask;
            done = '0;
            jdone = '0;
            forever begin
                for (int k = 0; k < N; k++) begin
                    if (k != lastk && !done[k]) begin
                        if (rep[k] && !jdone[k]) begin
                            if ($urandom_range(1, 0) == 1) begin drive(k, 1'b0); jdone[k] = 1'b1; end
                        end else if ($urandom_range(1, 0) == 1) begin
                            drive(k, 1'b1);
                            done[k] = 1'b1;
                        end
                    end
                end
                if ((done | lmask) == {N{1'b1}}) break;
                step();
                garbage();
            end
            if ($urandom_range(1, 0) == 1) begin step(); garbage(); end
            drive(lastk, 1'b1);
        end
        m_nw = t_nw; m_nd = t_nd; m_nws = t_nws;
        for (int i = 0; i < 2; i++) begin
            model_draw(m_lfsr[i], j, m_thr[i], m_total);
            m_lfsr[i]  = lfsr_next(m_lfsr[i]);
            m_topic[i] = 32'(j);
            m_off[i]   = 3 + 50 * N + j;
        end
        m_cap = cyc;
        step();
        garbage();
        if (inj_err) begin
            repeat ($urandom_range(150, 1)) begin step(); garbage(); end
            vld = N'($urandom_range((1 << N) - 1, 1));
            if (m_err_at < 0) m_err_at = cyc + 1;
            step();
            garbage();
        end else if (inj_rst) begin
            repeat ($urandom_range(150, 1)) begin step(); garbage(); end
            rst_n = 1'b0;
            m_cap = -1;
            m_topic = '{32'd0, 32'd0};
            m_prev = '{32'd0, 32'd0};
            m_err_at = -1;
            m_lfsr = '{SeedA, SeedB};
            step();
            rst_n = 1'b1;
        end
    endtask

    initial begin : stimulus
        garbage();
        repeat (2) step();
        chk_en = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // Topic 2 dominant: seed 0x8000 lands in topic 2, seed 1 in topic 0.
        set_all(32'd0, 32'd0, 32'd0);
        t_nw[2] = 32'd100;
        t_nd[2] = 32'd100;
        txn(1'b1, '0, 1'b0, 1'b0);
        check("model_total", m_total, 32'd41795584);
        check("model_thr_a", m_thr[0], 32'd20897792);
        check("model_thr_b", m_thr[1], 32'd637);
        wait_idle();
        check("dominant_topic_a", nt[0], 32'd2);
        check("dominant_topic_b", nt[1], 32'd0);
        check("busy_after_b", 32'(bsy[1]), 32'd0);

        // Staggered strobes, topic 1 repeated with the final nw=5, plus a stray strobe in CALC.
        set_all(32'd3, 32'd7, 32'd40);
        t_nw[1] = 32'd5;
        txn(1'b0, 4'b0010, 1'b1, 1'b0);
        wait_idle();
        check("err_sticky_a", 32'(er[0]), 32'd1);
        check("err_sticky_b", 32'(er[1]), 32'd1);

        // Saturating operands: every weight and cum pins at 0xFFFF_FFFF.
        set_all(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        txn(1'b1, '0, 1'b0, 1'b0);
        check("model_sat_total", m_total, 32'hFFFF_FFFF);
        wait_idle();
        check("sat_topic_a", nt[0], 32'd0);
        check("sat_topic_b", nt[1], 32'd0);

        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < N; k++) begin
                t_nw[k] = rand_count();
                t_nd[k] = rand_count();
                case ($urandom_range(3, 0))
                    0: t_nws[k] = 32'd0;
                    1: t_nws[k] = $urandom_range(5000, 0);
                    2: t_nws[k] = 32'hFFFF_FFF0;
                    default: t_nws[k] = $urandom;
                endcase
            end
            txn(1'($urandom_range(1, 0)), '0, ($urandom_range(5, 0) == 0),
                ($urandom_range(7, 0) == 0));
        end

        // Reset mid-CALC, then the all-zero transaction from a fresh seed.
        set_all(32'd0, 32'd0, 32'd0);
        txn(1'b1, '0, 1'b0, 1'b1);
        txn(1'b1, '0, 1'b0, 1'b0);
        wait_idle();
        check("uniform_topic_a", nt[0], 32'd2);
        check("uniform_topic_b", nt[1], 32'd0);
        check("uniform_latency_a", 32'(obs_valid[0] - m_cap), 32'd205);
        check("uniform_latency_b", 32'(obs_valid[1] - m_cap), 32'd203);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
